// File: rtl/lcd_io_driver_if.sv
// Bundles the CPU LCD output word with the board-side LCD pins and status returns.
// master = CPU/top-level side driving the word, slave = the LCD write-cycle engine.
interface lcd_io_driver_if;
   logic [31:0] io_lcd_i;
   logic [7:0]  lcd_data_o;
   logic        lcd_rs_o;
   logic        lcd_rw_o;
   logic        lcd_en_o;
   logic        lcd_on_o;
   logic        lcd_blon_o;
   logic        busy_o;
   logic        ack_o;
   logic        done_o;

   modport master (
      output io_lcd_i,
      input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o,
      input  busy_o, ack_o, done_o
   );

   modport slave (
      input  io_lcd_i,
      output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o,
      output busy_o, ack_o, done_o
   );
endinterface

// File: rtl/lcd_io_driver.sv
// Turns each REQ toggle in the CPU LCD word into one timed HD44780 write cycle:
// setup, EN pulse, hold, then the command execution wait.
module lcd_io_driver #(
   parameter int unsigned T_SETUP    = 4,
   parameter int unsigned T_EN       = 12,
   parameter int unsigned T_HOLD     = 4,
   parameter int unsigned T_CMD_WAIT = 2000,
   parameter int unsigned T_CLR_WAIT = 82000
) (
   input logic           clk_i,
   input logic           rst_ni,
   lcd_io_driver_if.slave bus
);

   localparam int unsigned MAX_AB = (T_SETUP > T_EN) ? T_SETUP : T_EN;
   localparam int unsigned MAX_CD = (T_HOLD > T_CMD_WAIT) ? T_HOLD : T_CMD_WAIT;
   localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MAX_T = (MAX_ABCD > T_CLR_WAIT) ? MAX_ABCD : T_CLR_WAIT;
   localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD_WAIT - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(T_CLR_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [7:0]       data_reg;
   logic             rs_reg;
   logic             en_reg;
   logic             on_reg;
   logic             blon_reg;
   logic             busy_reg;
   logic             ack_reg;
   logic             done_reg;
   logic             req_seen_reg;

   logic             long_wait;
   logic [CNT_W-1:0] wait_last;
   logic             unused_bits;

   // Clear-display and return-home need the long execution wait.
   assign long_wait = !rs_reg && (data_reg == 8'h01 || data_reg == 8'h02 || data_reg == 8'h03);
   assign wait_last = long_wait ? CLR_LAST : CMD_LAST;
   assign unused_bits = ^bus.io_lcd_i[29:10];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         data_reg     <= 8'h00;
         rs_reg       <= 1'b0;
         en_reg       <= 1'b0;
         on_reg       <= 1'b0;
         blon_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         done_reg     <= 1'b0;
         req_seen_reg <= bus.io_lcd_i[9];
      end else begin
         on_reg   <= bus.io_lcd_i[31];
         blon_reg <= bus.io_lcd_i[30];
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.io_lcd_i[9] != req_seen_reg) begin
                  data_reg     <= bus.io_lcd_i[7:0];
                  rs_reg       <= bus.io_lcd_i[8];
                  req_seen_reg <= bus.io_lcd_i[9];
                  busy_reg     <= 1'b1;
                  cnt_reg      <= '0;
                  state_reg    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_reg == SETUP_LAST) begin
                  cnt_reg   <= '0;
                  en_reg    <= 1'b1;
                  state_reg <= ST_PULSE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_PULSE: begin
               if (cnt_reg == EN_LAST) begin
                  cnt_reg   <= '0;
                  en_reg    <= 1'b0;
                  state_reg <= ST_HOLD;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_reg == HOLD_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_WAIT;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (cnt_reg == wait_last) begin
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  ack_reg   <= ~ack_reg;
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               cnt_reg   <= '0;
               en_reg    <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.lcd_data_o = data_reg;
   assign bus.lcd_rs_o   = rs_reg;
   assign bus.lcd_rw_o   = 1'b0;
   assign bus.lcd_en_o   = en_reg;
   assign bus.lcd_on_o   = on_reg;
   assign bus.lcd_blon_o = blon_reg;
   assign bus.busy_o     = busy_reg;
   assign bus.ack_o      = ack_reg;
   assign bus.done_o     = done_reg;

endmodule

// File: tb/tb_lcd_io_driver.sv
// Directed bench for lcd_io_driver: a scoreboard of expected transfers is checked
// against each done_o pulse, plus directed checks on reset, freezing and abort.
module tb_lcd_io_driver;
   localparam int unsigned T_SETUP    = 2;
   localparam int unsigned T_EN       = 3;
   localparam int unsigned T_HOLD     = 2;
   localparam int unsigned T_CMD_WAIT = 10;
   localparam int unsigned T_CLR_WAIT = 40;

   typedef struct {
      logic [7:0] data;
      logic       rs;
      int         busy_len;
      int         en_len;
      logic       ack;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   lcd_io_driver_if bus();

   lcd_io_driver #(
      .T_SETUP   (T_SETUP),
      .T_EN      (T_EN),
      .T_HOLD    (T_HOLD),
      .T_CMD_WAIT(T_CMD_WAIT),
      .T_CLR_WAIT(T_CLR_WAIT)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   done_total = 0;
   int   busy_total = 0;
   int   busy_cnt = 0;
   int   en_cnt = 0;
   int   idle_cnt = 0;
   int   last_gap = -1;
   logic busy_prev = 1'b0;
   logic req_lvl = 1'b1;
   logic exp_ack = 1'b0;
   logic [1:0] on_blon = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Toggle REQ with a new data/RS; optionally queue the expected completion.
   task automatic issue(input logic [7:0] data, input logic rs, input bit push);
      exp_t e;
      req_lvl = ~req_lvl;
      bus.io_lcd_i = {on_blon, 20'h0, req_lvl, rs, data};
      if (push) begin
         exp_ack = ~exp_ack;
         e.data = data;
         e.rs = rs;
         e.en_len = int'(T_EN);
         e.busy_len = int'(T_SETUP + T_EN + T_HOLD) +
                      ((!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03))
                       ? int'(T_CLR_WAIT) : int'(T_CMD_WAIT));
         e.ack = exp_ack;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (bus.busy_o && n < max) begin
         @(negedge clk);
         n++;
      end
      check("busy_timeout", {31'b0, bus.busy_o}, 32'd0);
   endtask

   // Monitor: measures each busy run and EN pulse, scores it on done_o.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.busy_o && !busy_prev) begin
            last_gap = idle_cnt;
            idle_cnt = 0;
            busy_cnt = 0;
            en_cnt = 0;
         end
         if (bus.busy_o) begin
            busy_cnt++;
            busy_total++;
         end else begin
            idle_cnt++;
         end
         if (bus.lcd_en_o) en_cnt++;
         if (bus.done_o) begin
            done_total++;
            if (sb_q.size() == 0) begin
               check("unexpected_done_qsize", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               check("sb_busy_len", 32'(busy_cnt), 32'(e.busy_len));
               check("sb_en_len", 32'(en_cnt), 32'(e.en_len));
               check("sb_data", {24'b0, bus.lcd_data_o}, {24'b0, e.data});
               check("sb_rs", {31'b0, bus.lcd_rs_o}, {31'b0, e.rs});
               check("sb_ack", {31'b0, bus.ack_o}, {31'b0, e.ack});
               check("sb_rw", {31'b0, bus.lcd_rw_o}, 32'd0);
            end
            $display("txn done: data=%02h rs=%0d busy=%0d en=%0d ack=%0d",
                     bus.lcd_data_o, bus.lcd_rs_o, busy_cnt, en_cnt, bus.ack_o);
         end
         busy_prev = bus.busy_o;
      end
   end

   initial begin
      int d0;
      // Reset with a pre-existing REQ level of 1.
      bus.io_lcd_i = 32'h0000_0200;
      tick(3);
      check("rst_data", {24'b0, bus.lcd_data_o}, 32'd0);
      check("rst_en", {31'b0, bus.lcd_en_o}, 32'd0);
      check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
      check("rst_ack", {31'b0, bus.ack_o}, 32'd0);
      check("rst_rw", {31'b0, bus.lcd_rw_o}, 32'd0);
      rst_n = 1'b1;
      tick(20);
      check("idle_busy_total", 32'(busy_total), 32'd0);
      check("idle_done_total", 32'(done_total), 32'd0);
      check("idle_pins", {22'b0, bus.lcd_data_o, bus.lcd_rs_o, bus.lcd_en_o},
            32'd0);
      check("idle_on_blon", {30'b0, bus.lcd_on_o, bus.lcd_blon_o}, 32'd0);

      // Data write 0x41, RS=1, ON/BLON set: word 0xC000_0141.
      on_blon = 2'b11;
      issue(8'h41, 1'b1, 1'b1);
      check("word_c0000141", bus.io_lcd_i, 32'hC000_0141);
      tick(1);
      check("wr_data", {24'b0, bus.lcd_data_o}, 32'h41);
      check("wr_rs", {31'b0, bus.lcd_rs_o}, 32'd1);
      check("wr_busy", {31'b0, bus.busy_o}, 32'd1);
      check("wr_on_blon", {30'b0, bus.lcd_on_o, bus.lcd_blon_o}, 32'd3);
      check("wr_en_setup", {31'b0, bus.lcd_en_o}, 32'd0);
      tick(1);
      check("wr_en_setup2", {31'b0, bus.lcd_en_o}, 32'd0);
      tick(1);
      check("wr_en_rise", {31'b0, bus.lcd_en_o}, 32'd1);
      wait_idle(200);
      tick(2);
      check("wr_ack", {31'b0, bus.ack_o}, 32'd1);

      // Clear display (long wait) then function set (short wait).
      issue(8'h01, 1'b0, 1'b1);
      tick(1);
      wait_idle(200);
      tick(2);
      issue(8'h38, 1'b0, 1'b1);
      tick(1);
      wait_idle(200);
      tick(2);

      // Data changes during PULSE are ignored; REQ toggled during WAIT queues the next.
      issue(8'h55, 1'b1, 1'b1);
      tick(3);
      check("frz_en_pulse", {31'b0, bus.lcd_en_o}, 32'd1);
      bus.io_lcd_i[7:0] = 8'hFF;
      tick(1);
      check("frz_data", {24'b0, bus.lcd_data_o}, 32'h55);
      check("frz_rs", {31'b0, bus.lcd_rs_o}, 32'd1);
      tick(6);
      issue(8'h66, 1'b0, 1'b1);
      wait_idle(200);
      tick(2);
      check("b2b_busy", {31'b0, bus.busy_o}, 32'd1);
      check("b2b_gap", 32'(last_gap), 32'd1);
      wait_idle(200);
      tick(2);

      // Reset during PULSE aborts without completion.
      issue(8'h77, 1'b1, 1'b0);
      tick(3);
      check("abort_en_pre", {31'b0, bus.lcd_en_o}, 32'd1);
      d0 = done_total;
      rst_n = 1'b0;
      exp_ack = 1'b0;
      tick(1);
      check("abort_en", {31'b0, bus.lcd_en_o}, 32'd0);
      check("abort_busy", {31'b0, bus.busy_o}, 32'd0);
      check("abort_ack", {31'b0, bus.ack_o}, 32'd0);
      check("abort_done", {31'b0, bus.done_o}, 32'd0);
      rst_n = 1'b1;
      tick(30);
      check("abort_no_restart", {31'b0, bus.busy_o}, 32'd0);
      check("abort_done_cnt", 32'(done_total), 32'(d0));

      // Two REQ toggles within one busy period cancel.
      d0 = done_total;
      issue(8'h10, 1'b1, 1'b1);
      tick(4);
      req_lvl = ~req_lvl;
      bus.io_lcd_i[9] = req_lvl;
      tick(3);
      req_lvl = ~req_lvl;
      bus.io_lcd_i[9] = req_lvl;
      wait_idle(200);
      tick(30);
      check("cancel_done_cnt", 32'(done_total), 32'(d0 + 1));
      check("cancel_busy", {31'b0, bus.busy_o}, 32'd0);
      check("cancel_ack", {31'b0, bus.ack_o}, {31'b0, exp_ack});
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end
endmodule
